cic3_row_readout_sched: RTL

- Readout scheduler for one 2x12 CIC3 filter row: 24 channels, each with a 25-bit output.
- Detects each decimated output period from the row's divided clock, waits a settle interval, then snapshots all 24 filter outputs in one cycle.
- Streams the enabled channels out one word at a time over a valid/ready interface to the row readout/serializer logic.
- Reports missed frames as overruns.

---
 rtl/cic3_row_readout_sched.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/cic3_row_readout_sched.sv
// -----------------------------------------------------------------------------
// cic3_row_readout_sched
//
// Readout scheduler for one 2x12 CIC3 filter row (24 channels, 25-bit outputs).
// Each rising edge of the row's divided clock marks a new decimated output.
// The block waits a programmable settle interval, snapshots every filter output
// and the channel enable mask in a single cycle, then streams the enabled
// channels out, lowest index first, over a valid/ready interface. A new edge
// that arrives while a frame is still in flight is dropped and flagged as a
// sticky overrun.
//
// Ports:
//   clk          filter high-speed clock, the only clock of the block
//   reset        synchronous, active-high reset
//   div_clk      row divided clock (generated from clk, already synchronous)
//   filt_out     flattened filter outputs, channel k at [(k+1)*DW-1:k*DW]
//   chan_en      channel enable mask, bit k enables channel k
//   settle_cyc   clk cycles to wait after a div_clk rise before the snapshot
//   out_valid    output word valid
//   out_ready    downstream accepts the word
//   out_data     snapshotted filter value
//   out_chan     channel index of out_data
//   out_last     last enabled channel of the frame
//   busy         high whenever the scheduler is not idle
//   overrun      sticky flag, set when a frame is dropped
//   frame_cnt    number of frames snapshotted, wraps at 2^16
//   clr_overrun  synchronous clear of overrun (wins over a simultaneous set)
// -----------------------------------------------------------------------------
module cic3_row_readout_sched #(
   parameter int NUM_CH   = 24,
   parameter int DW       = 25,
   parameter int SETTLE_W = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   div_clk,
   input  logic [NUM_CH*DW-1:0]   filt_out,
   input  logic [NUM_CH-1:0]      chan_en,
   input  logic [SETTLE_W-1:0]    settle_cyc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DW-1:0]          out_data,
   output logic [4:0]             out_chan,
   output logic                   out_last,
   output logic                   busy,
   output logic                   overrun,
   output logic [15:0]            frame_cnt,
   input  logic                   clr_overrun
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2,
      SCAN    = 2'd3
   } state_t;

   // Lowest set bit of mask at or above index start (0 when none).
   function automatic logic [4:0] first_set(input logic [NUM_CH-1:0] mask,
                                            input logic [5:0]        start);
      logic [4:0] idx;
      idx = 5'd0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         idx = (mask[i] && (i >= int'(start))) ? 5'(i) : idx;
      end
      return idx;
   endfunction

   // True when no bit of mask is set strictly above index idx.
   function automatic logic none_above(input logic [NUM_CH-1:0] mask,
                                       input logic [4:0]        idx);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         hit = hit | (mask[i] & (i > int'(idx)));
      end
      return ~hit;
   endfunction

   state_t               state_r;
   state_t               next_state_s;
   logic                 div_clk_d_r;
   logic                 rise_s;
   logic                 accept_s;
   logic [SETTLE_W-1:0]  cnt_r;
   logic [SETTLE_W-1:0]  cnt_nxt_s;
   logic [DW-1:0]        snap_r [NUM_CH];
   logic [NUM_CH-1:0]    en_latched_r;

   logic                 out_valid_r, out_valid_nxt_s;
   logic [DW-1:0]        out_data_r,  out_data_nxt_s;
   logic [4:0]           out_chan_r,  out_chan_nxt_s;
   logic                 out_last_r,  out_last_nxt_s;
   logic                 busy_r,      busy_nxt_s;
   logic                 overrun_r,   overrun_nxt_s;
   logic [15:0]          frame_cnt_r, frame_cnt_nxt_s;

   // Candidate words: first word of a new capture, and next word of a scan.
   logic [4:0]           cap_idx_s, nxt_idx_s;
   logic                 cap_last_s, nxt_last_s;
   logic [DW-1:0]        cap_data_s, nxt_data_s;

   assign rise_s   = div_clk & ~div_clk_d_r;
   assign accept_s = out_valid_r & out_ready;

   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_chan  = out_chan_r;
   assign out_last  = out_last_r;
   assign busy      = busy_r;
   assign overrun   = overrun_r;
   assign frame_cnt = frame_cnt_r;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic. The CAPTURE decision looks at chan_en directly because
   // that is the value being latched into en_latched on this very edge.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (rise_s) begin
               next_state_s = (settle_cyc == {SETTLE_W{1'b0}}) ? CAPTURE : SETTLE;
            end else begin
               next_state_s = IDLE;
            end
         end
         SETTLE: begin
            if (cnt_r <= SETTLE_W'(1)) begin
               next_state_s = CAPTURE;
            end else begin
               next_state_s = SETTLE;
            end
         end
         CAPTURE: begin
            if (chan_en == {NUM_CH{1'b0}}) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = SCAN;
            end
         end
         SCAN: begin
            if (accept_s && out_last_r) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = SCAN;
            end
         end
         default: next_state_s = IDLE;
      endcase
   end

   // Priority search for the first word of a capture and the next word of a scan.
   always_comb begin
      cap_idx_s  = first_set(chan_en, 6'd0);
      cap_last_s = none_above(chan_en, cap_idx_s);
      nxt_idx_s  = first_set(en_latched_r, {1'b0, out_chan_r} + 6'd1);
      nxt_last_s = none_above(en_latched_r, nxt_idx_s);
      cap_data_s = {DW{1'b0}};
      nxt_data_s = {DW{1'b0}};
      for (int k = 0; k < NUM_CH; k++) begin
         cap_data_s = (5'(k) == cap_idx_s) ? filt_out[k*DW +: DW] : cap_data_s;
         nxt_data_s = (5'(k) == nxt_idx_s) ? snap_r[k] : nxt_data_s;
      end
   end

   // Output logic: next values of every registered output and the settle counter.
   always_comb begin
      out_valid_nxt_s = (next_state_s == SCAN);
      busy_nxt_s      = (next_state_s != IDLE);
      out_data_nxt_s  = out_data_r;
      out_chan_nxt_s  = out_chan_r;
      out_last_nxt_s  = out_last_r;
      cnt_nxt_s       = cnt_r;
      case (state_r)
         IDLE: begin
            if (rise_s) begin
               cnt_nxt_s = settle_cyc;
            end else begin
               cnt_nxt_s = cnt_r;
            end
         end
         SETTLE: begin
            cnt_nxt_s = cnt_r - SETTLE_W'(1);
         end
         CAPTURE: begin
            if (next_state_s == SCAN) begin
               out_data_nxt_s = cap_data_s;
               out_chan_nxt_s = cap_idx_s;
               out_last_nxt_s = cap_last_s;
            end else begin
               out_data_nxt_s = {DW{1'b0}};
               out_chan_nxt_s = 5'd0;
               out_last_nxt_s = 1'b0;
            end
         end
         SCAN: begin
            if (accept_s && !out_last_r) begin
               out_data_nxt_s = nxt_data_s;
               out_chan_nxt_s = nxt_idx_s;
               out_last_nxt_s = nxt_last_s;
            end else if (accept_s) begin
               out_data_nxt_s = {DW{1'b0}};
               out_chan_nxt_s = 5'd0;
               out_last_nxt_s = 1'b0;
            end else begin
               // Stalled: hold the presented word.
               out_data_nxt_s = out_data_r;
               out_chan_nxt_s = out_chan_r;
               out_last_nxt_s = out_last_r;
            end
         end
         default: begin
            cnt_nxt_s = cnt_r;
         end
      endcase

      if (state_r == CAPTURE) begin
         frame_cnt_nxt_s = frame_cnt_r + 16'd1;
      end else begin
         frame_cnt_nxt_s = frame_cnt_r;
      end

      // Any rise outside IDLE (including the cycle a frame ends) drops a frame.
      if (clr_overrun) begin
         overrun_nxt_s = 1'b0;
      end else if (rise_s && (state_r != IDLE)) begin
         overrun_nxt_s = 1'b1;
      end else begin
         overrun_nxt_s = overrun_r;
      end
   end

   // Datapath registers: edge flop, snapshot, enable latch and outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_clk_d_r  <= 1'b1;
         cnt_r        <= {SETTLE_W{1'b0}};
         en_latched_r <= {NUM_CH{1'b0}};
         for (int k = 0; k < NUM_CH; k++) begin
            snap_r[k] <= {DW{1'b0}};
         end
         out_valid_r  <= 1'b0;
         out_data_r   <= {DW{1'b0}};
         out_chan_r   <= 5'd0;
         out_last_r   <= 1'b0;
         busy_r       <= 1'b0;
         overrun_r    <= 1'b0;
         frame_cnt_r  <= 16'd0;
      end else begin
         div_clk_d_r <= div_clk;
         cnt_r       <= cnt_nxt_s;
         if (state_r == CAPTURE) begin
            en_latched_r <= chan_en;
            for (int k = 0; k < NUM_CH; k++) begin
               snap_r[k] <= filt_out[k*DW +: DW];
            end
         end else begin
            en_latched_r <= en_latched_r;
         end
         out_valid_r <= out_valid_nxt_s;
         out_data_r  <= out_data_nxt_s;
         out_chan_r  <= out_chan_nxt_s;
         out_last_r  <= out_last_nxt_s;
         busy_r      <= busy_nxt_s;
         overrun_r   <= overrun_nxt_s;
         frame_cnt_r <= frame_cnt_nxt_s;
      end
   end

endmodule
